// File: rtl/pipe_scoreboard.sv
// Per-register write scoreboard: tracks in-flight producers by age and latency,
// and drives the issue stall, the bypass selects and a saturating stall counter.
module pipe_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int AGE_W      = 2,
  parameter int FLUSH_AGE  = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_vld,
  input  logic                  issue_wr,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [AGE_W-1:0]      issue_lat,
  input  logic [REG_ADDR_W-1:0] issue_rs,
  input  logic [REG_ADDR_W-1:0] issue_rt,
  input  logic                  issue_rs_used,
  input  logic                  issue_rt_used,
  input  logic                  flush,
  output logic                  stall,
  output logic                  fwd_rs_vld,
  output logic                  fwd_rt_vld,
  output logic [AGE_W-1:0]      fwd_rs_dist,
  output logic [AGE_W-1:0]      fwd_rt_dist,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam logic [AGE_W-1:0] DEPTH_A = AGE_W'(DEPTH);
  localparam logic [AGE_W-1:0] ONE_A   = AGE_W'(1);

  logic [NUM_REGS-1:0]            busy_q, busy_d;
  logic [NUM_REGS-1:0][AGE_W-1:0] age_q, age_d;
  logic [NUM_REGS-1:0][AGE_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;

  logic [AGE_W-1:0] lat_eff;
  logic             rs_hit, rt_hit;
  logic             rs_pend, rt_pend;
  logic             raw, waw, accept;

  always_comb begin
    lat_eff = issue_lat;
    if (issue_lat == '0) begin
      lat_eff = ONE_A;
    end else if (issue_lat > DEPTH_A) begin
      lat_eff = DEPTH_A;
    end
  end

  // An entry at age DEPTH writes the regfile this edge, so readers see it there.
  assign rs_hit = issue_rs_used && (issue_rs != '0) &&
                  busy_q[issue_rs] && (age_q[issue_rs] != DEPTH_A);
  assign rt_hit = issue_rt_used && (issue_rt != '0) &&
                  busy_q[issue_rt] && (age_q[issue_rt] != DEPTH_A);

  assign rs_pend = cnt_q[issue_rs] != '0;
  assign rt_pend = cnt_q[issue_rt] != '0;

  assign raw = (rs_hit && rs_pend) || (rt_hit && rt_pend);
  assign waw = issue_wr && (issue_rd != '0) &&
               busy_q[issue_rd] && (age_q[issue_rd] < DEPTH_A);

  assign stall  = issue_vld && !flush && (raw || waw);
  assign accept = issue_vld && !stall && !flush &&
                  issue_wr && (issue_rd != '0);

  assign fwd_rs_vld  = rs_hit && !rs_pend;
  assign fwd_rt_vld  = rt_hit && !rt_pend;
  assign fwd_rs_dist = fwd_rs_vld ? age_q[issue_rs] : '0;
  assign fwd_rt_dist = fwd_rt_vld ? age_q[issue_rt] : '0;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    busy_d = '0;
    age_d  = '0;
    cnt_d  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (accept && (issue_rd == REG_ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
        age_d[r]  = ONE_A;
        cnt_d[r]  = lat_eff - ONE_A;
      end else if (busy_q[r] && (age_q[r] != DEPTH_A) &&
                   !(flush && (int'(age_q[r]) < FLUSH_AGE))) begin
        busy_d[r] = 1'b1;
        age_d[r]  = age_q[r] + ONE_A;
        cnt_d[r]  = (cnt_q[r] == '0) ? '0 : cnt_q[r] - ONE_A;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      age_q       <= '0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      age_q       <= age_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
